// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target (CPOL=0, CPHA=0), 8-bit frames, MSB first.
// SCLK, CS_N and COPI are oversampled by clk_i through SyncStages flops;
// every SPI action is an edge seen in the clk_i domain.
//
// Ports
//   clk_i, rst_i            system clock, synchronous active-high reset
//   spi_sck_i/_cs_ni/_copi_i SPI pins from the external controller
//   spi_cipo_o, spi_cipo_en_o target data out and its output enable
//   tx_data_i/_valid_i, tx_ready_o   byte stream into the TX holding register
//   rx_data_o/_valid_o, rx_ready_i   received byte stream
//   rx_overrun_o, tx_underrun_o, frame_abort_o   one-cycle event pulses
module spi_target #(
  parameter int unsigned SyncStages = 2,
  parameter logic [7:0]  IdleByte   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_ni,
  input  logic       spi_copi_i,
  output logic       spi_cipo_o,
  output logic       spi_cipo_en_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  output logic       tx_underrun_o,
  output logic       frame_abort_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_n;

  logic [SyncStages-1:0] sck_sync, cs_sync, copi_sync;
  logic sck_s, cs_s, copi_s;
  logic sck_d, cs_d;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  logic [2:0] bit_cnt;
  logic [7:0] tx_shift, rx_shift, hold_data;
  logic       hold_full;
  logic       tx_accept;

  logic load_tx, shift_tx, shift_rx, frame_start, frame_end, abort;

  // Chains reset to 0 (CS seen as asserted): a CS pin already low when
  // reset releases produces no edge, and a high CS gives a cs_rise that
  // IDLE ignores, so no frame starts until CS genuinely toggles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      copi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SyncStages-2:0], spi_sck_i};
      cs_sync   <= {cs_sync[SyncStages-2:0], spi_cs_ni};
      copi_sync <= {copi_sync[SyncStages-2:0], spi_copi_i};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s  = sck_sync[SyncStages-1];
  assign cs_s   = cs_sync[SyncStages-1];
  assign copi_s = copi_sync[SyncStages-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  assign tx_ready_o = ~hold_full & ~rst_i;
  assign tx_accept  = tx_valid_i & tx_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    load_tx       = 1'b0;
    shift_tx      = 1'b0;
    shift_rx      = 1'b0;
    frame_start   = 1'b0;
    frame_end     = 1'b0;
    abort         = 1'b0;
    spi_cipo_o    = 1'b0;
    spi_cipo_en_o = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n     = ACTIVE;
          frame_start = 1'b1;
          load_tx     = 1'b1;
        end
      end
      ACTIVE: begin
        spi_cipo_o    = tx_shift[7];
        spi_cipo_en_o = 1'b1;
        // CS release takes priority over any SCLK edge seen in the same cycle.
        if (cs_rise) begin
          state_n   = IDLE;
          frame_end = 1'b1;
          abort     = (bit_cnt != 3'd0);
        end else begin
          shift_rx = sck_rise;
          if (sck_fall) begin
            load_tx  = (bit_cnt == 3'd0);
            shift_tx = (bit_cnt != 3'd0);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt       <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      hold_data     <= '0;
      hold_full     <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      rx_overrun_o  <= 1'b0;
      tx_underrun_o <= 1'b0;
      frame_abort_o <= 1'b0;
    end else begin
      rx_overrun_o  <= 1'b0;
      tx_underrun_o <= 1'b0;
      frame_abort_o <= abort;

      if (load_tx) begin
        if (hold_full) begin
          tx_shift <= hold_data;
        end else begin
          tx_shift      <= IdleByte;
          tx_underrun_o <= 1'b1;
        end
      end else if (shift_tx) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      // Accept only happens while empty, so a same-cycle reload has
      // already taken IdleByte and the new byte waits for the next boundary.
      if (load_tx && hold_full) begin
        hold_full <= 1'b0;
      end
      if (tx_accept) begin
        hold_full <= 1'b1;
        hold_data <= tx_data_i;
      end

      if (frame_start || frame_end) begin
        bit_cnt <= '0;
      end else if (shift_rx) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (shift_rx) begin
        rx_shift <= {rx_shift[6:0], copi_s};
      end

      if (shift_rx && bit_cnt == 3'd7) begin
        rx_data_o  <= {rx_shift[6:0], copi_s};
        rx_valid_o <= 1'b1;
        if (rx_valid_o && !rx_ready_i) begin
          rx_overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck, cs_n, copi;
  logic       cipo, cipo_en;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       rx_overrun, tx_underrun, frame_abort;

  int checks   = 0;
  int failures = 0;

  int   n_und = 0, n_ovr = 0, n_abt = 0, n_rxv = 0;
  logic rxv_prev = 1'b0;

  always #5 clk = ~clk;

  spi_target #(.SyncStages(2), .IdleByte(8'hFF)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .spi_sck_i     (sck),
    .spi_cs_ni     (cs_n),
    .spi_copi_i    (copi),
    .spi_cipo_o    (cipo),
    .spi_cipo_en_o (cipo_en),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .rx_overrun_o  (rx_overrun),
    .tx_underrun_o (tx_underrun),
    .frame_abort_o (frame_abort)
  );

  // Event counters for the one-cycle pulses and rx_valid rising edges.
  always @(negedge clk) begin
    if (tx_underrun === 1'b1) n_und++;
    if (rx_overrun === 1'b1) n_ovr++;
    if (frame_abort === 1'b1) n_abt++;
    if (rx_valid === 1'b1 && rxv_prev !== 1'b1) n_rxv++;
    rxv_prev = rx_valid;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    tick(4);
    cs_n = 1'b1;
    tick(8);
  endtask

  // SCLK = f_clk/8. CIPO is sampled at the end of each low phase.
  task automatic xfer(input logic [7:0] mosi, input int unsigned nbits,
                      input bit last_fall, output logic [7:0] miso);
    logic [2:0] bi;
    miso = '0;
    for (int unsigned k = 0; k < nbits; k++) begin
      bi   = 3'(7 - k);
      copi = mosi[bi];
      tick(4);
      miso[bi] = cipo;
      sck = 1'b1;
      tick(4);
      if (k != nbits - 1 || last_fall) sck = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; copi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    tick(3);
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++; $display("FAIL reset_tx_ready_in_reset got=%b exp=0", tx_ready);
    end
    checks++;
    if ({cipo, cipo_en, rx_valid, rx_overrun, tx_underrun, frame_abort} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {cipo, cipo_en, rx_valid, rx_overrun, tx_underrun, frame_abort});
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++; $display("FAIL reset_tx_ready_after got=%b exp=1", tx_ready);
    end
    checks++;
    if (rx_data !== 8'h00) begin
      failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data);
    end
    tick(8);
  endtask

  task automatic test_basic();
    logic [7:0] m;
    int v0;
    preload(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++; $display("FAIL basic_hold_full got=%b exp=0", tx_ready);
    end
    v0 = n_rxv;
    cs_low();
    checks++;
    if (tx_ready !== 1'b1 || cipo_en !== 1'b1) begin
      failures++; $display("FAIL basic_after_load ready/en got=%b%b exp=11", tx_ready, cipo_en);
    end
    xfer(8'h3C, 8, 1'b1, m);
    checks++;
    if (m !== 8'hA5) begin
      failures++; $display("FAIL basic_cipo got=%h exp=a5", m);
    end
    tick(2);
    checks++;
    if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin
      failures++; $display("FAIL basic_rx got=%h/%b exp=3c/1", rx_data, rx_valid);
    end
    checks++;
    if (n_rxv - v0 !== 1) begin
      failures++; $display("FAIL basic_rx_valid_count got=%0d exp=1", n_rxv - v0);
    end
    cs_high();
    checks++;
    if (cipo_en !== 1'b0 || cipo !== 1'b0) begin
      failures++; $display("FAIL basic_idle_cipo en/d got=%b%b exp=00", cipo_en, cipo);
    end
    drain();
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++; $display("FAIL basic_rx_clear got=%b exp=0", rx_valid);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] m1, m2;
    int u0;
    u0 = n_und;
    cs_low();
    xfer(8'h11, 8, 1'b1, m1);
    xfer(8'h22, 8, 1'b0, m2);
    tick(2);
    checks++;
    if (m1 !== 8'hFF || m2 !== 8'hFF) begin
      failures++; $display("FAIL underrun_cipo got=%h %h exp=ff ff", m1, m2);
    end
    checks++;
    if (n_und - u0 !== 2) begin
      failures++; $display("FAIL underrun_count got=%0d exp=2", n_und - u0);
    end
    sck = 1'b0;
    cs_high();
    drain();
  endtask

  task automatic test_overrun();
    logic [7:0] m;
    int o0, v0;
    o0 = n_ovr;
    v0 = n_rxv;
    cs_low();
    xfer(8'h01, 8, 1'b1, m);
    xfer(8'h02, 8, 1'b1, m);
    xfer(8'h03, 8, 1'b1, m);
    cs_high();
    checks++;
    if (rx_data !== 8'h03 || rx_valid !== 1'b1) begin
      failures++; $display("FAIL overrun_rx got=%h/%b exp=03/1", rx_data, rx_valid);
    end
    checks++;
    if (n_ovr - o0 !== 2) begin
      failures++; $display("FAIL overrun_count got=%0d exp=2", n_ovr - o0);
    end
    checks++;
    if (n_rxv - v0 !== 1) begin
      failures++; $display("FAIL overrun_valid_rises got=%0d exp=1", n_rxv - v0);
    end
    drain();
  endtask

  task automatic test_abort();
    logic [7:0] m;
    int a0, v0;
    preload(8'h96);
    cs_low();
    preload(8'h4B);
    a0 = n_abt;
    v0 = n_rxv;
    xfer(8'hF0, 5, 1'b1, m);
    checks++;
    if (m[7:3] !== 5'b10010 || cipo_en !== 1'b1) begin
      failures++; $display("FAIL abort_partial_cipo got=%b en=%b exp=10010 en=1", m[7:3], cipo_en);
    end
    cs_high();
    checks++;
    if (n_abt - a0 !== 1) begin
      failures++; $display("FAIL abort_pulse got=%0d exp=1", n_abt - a0);
    end
    checks++;
    if (n_rxv - v0 !== 0 || rx_valid !== 1'b0 || cipo_en !== 1'b0) begin
      failures++;
      $display("FAIL abort_state rises=%0d valid=%b en=%b exp=0 0 0", n_rxv - v0, rx_valid, cipo_en);
    end
    cs_low();
    xfer(8'h00, 8, 1'b1, m);
    checks++;
    if (m !== 8'h4B) begin
      failures++; $display("FAIL abort_next_frame got=%h exp=4b", m);
    end
    cs_high();
    checks++;
    if (n_abt - a0 !== 1) begin
      failures++; $display("FAIL abort_full_frame_pulse got=%0d exp=1", n_abt - a0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] m1, m2, m3;
    int u0;
    u0 = n_und;
    cs_low();
    xfer(8'h00, 8, 1'b0, m1);
    // Byte-boundary reload lands on the third posedge after the SCLK fall.
    sck = 1'b0;
    tick(2);
    tx_data  = 8'h69;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(1);
    checks++;
    if (n_und - u0 !== 2 || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_coincident und=%0d ready=%b exp=2 0", n_und - u0, tx_ready);
    end
    xfer(8'h00, 8, 1'b1, m2);
    xfer(8'h5A, 8, 1'b1, m3);
    checks++;
    if (m1 !== 8'hFF || m2 !== 8'hFF || m3 !== 8'h69) begin
      failures++; $display("FAIL b2b_cipo got=%h %h %h exp=ff ff 69", m1, m2, m3);
    end
    cs_high();
    drain();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] m;
    int u0, a0;
    preload(8'hE7);
    u0 = n_und;
    a0 = n_abt;
    cs_low();
    preload(8'h3C);
    xfer(8'hAA, 4, 1'b1, m);
    rst = 1'b1;
    tick(1);
    checks++;
    if ({cipo, cipo_en, tx_ready, rx_valid, rx_overrun, tx_underrun, frame_abort} !== 7'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b exp=0000000",
               {cipo, cipo_en, tx_ready, rx_valid, rx_overrun, tx_underrun, frame_abort});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      failures++; $display("FAIL rst_mid_rx_data got=%h exp=00", rx_data);
    end
    tick(1);
    rst = 1'b0;
    tick(2);
    checks++;
    if (tx_ready !== 1'b1 || n_und - u0 !== 0 || n_abt - a0 !== 0) begin
      failures++;
      $display("FAIL rst_mid_after ready=%b und=%0d abt=%0d exp=1 0 0", tx_ready, n_und - u0, n_abt - a0);
    end
    cs_n = 1'b1;
    tick(8);
    preload(8'h81);
    cs_low();
    xfer(8'h55, 8, 1'b1, m);
    tick(2);
    checks++;
    if (m !== 8'h81 || rx_data !== 8'h55 || rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_clean_frame cipo=%h rx=%h v=%b exp=81 55 1", m, rx_data, rx_valid);
    end
    cs_high();
    checks++;
    if (n_abt - a0 !== 0) begin
      failures++; $display("FAIL rst_mid_no_abort got=%0d exp=0", n_abt - a0);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
